// File: rtl/maze_pkg.sv
// Shared maze bitmap geometry, writer FSM states and the source image generator.
package maze_pkg;

  localparam int unsigned MAZE_WORDS      = 600;
  localparam int unsigned MAZE_COLS       = 160;
  localparam int unsigned MAZE_ROWS       = 120;
  localparam int unsigned MAZE_CELL_SHIFT = 2;
  localparam int unsigned MAZE_DATA_W     = 32;
  localparam int unsigned MAZE_IMG_AW     = 12;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_ROM = 3'd2,
    WRITE    = 3'd3,
    DONE     = 3'd4
  } maze_state_e;

  // Stand-in image content: address in the upper half, its complement below.
  function automatic logic [MAZE_DATA_W-1:0] maze_word(input logic [MAZE_IMG_AW-1:0] a);
    return {4'hA, a, 4'h5, ~a};
  endfunction

endpackage

// File: rtl/maze_avl_writer_if.sv
// Avalon-MM write port between the maze writer (master) and the VGA maze RAM (slave).
interface maze_avl_writer_if #(
  parameter int unsigned ADDR_W = 10
);

  logic [ADDR_W-1:0] AVM_ADDR;
  logic              AVM_WRITE;
  logic              AVM_CS;
  logic [3:0]        AVM_BYTE_EN;
  logic [31:0]       AVM_WRITEDATA;
  logic              AVM_WAITREQUEST;

  modport master (
    output AVM_ADDR,
    output AVM_WRITE,
    output AVM_CS,
    output AVM_BYTE_EN,
    output AVM_WRITEDATA,
    input  AVM_WAITREQUEST
  );

  modport slave (
    input  AVM_ADDR,
    input  AVM_WRITE,
    input  AVM_CS,
    input  AVM_BYTE_EN,
    input  AVM_WRITEDATA,
    output AVM_WAITREQUEST
  );

endinterface

// File: rtl/maze_rom.sv
// Synchronous maze image ROM, one-cycle read latency; addresses past DEPTH read as zero.
module maze_rom
  import maze_pkg::*;
#(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 2400
) (
  input  logic                   CLK,
  input  logic [AW-1:0]          addr,
  output logic [MAZE_DATA_W-1:0] q
);

  logic [MAZE_DATA_W-1:0] q_d;
  logic [MAZE_DATA_W-1:0] q_q;
  logic [31:0]            addr_ext;

  always_comb begin
    q_d      = '0;
    addr_ext = 32'(addr);
    if (addr_ext < DEPTH) begin
      q_d = maze_word(MAZE_IMG_AW'(addr));
    end
  end

  always_ff @(posedge CLK) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/maze_avl_writer.sv
// Avalon-MM master that copies one stored maze (or zeros) into the VGA maze bitmap RAM.
module maze_avl_writer
  import maze_pkg::*;
#(
  parameter int unsigned NUM_WORDS = MAZE_WORDS,
  parameter int unsigned NUM_MAZES = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned ROM_AW    = 12
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   start,
  input  logic                   clear,
  input  logic [1:0]             maze_sel,
  output logic                   busy,
  output logic                   done,
  output logic [ROM_AW-1:0]      rom_addr,
  input  logic [MAZE_DATA_W-1:0] rom_q,
  maze_avl_writer_if.master      avm
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  maze_state_e            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   clr_q, clr_d;
  logic [1:0]             sel_q, sel_d;
  logic [ROM_AW-1:0]      rom_addr_q, rom_addr_d;
  logic [MAZE_DATA_W-1:0] wdata_q, wdata_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   write_q, write_d;
  logic [3:0]             be_q, be_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [31:0]            sel_ext;
  logic                   sel_ok;

  // Out-of-range maze indices fall back to a clear so the ROM is never over-read.
  always_comb begin
    sel_ext = 32'(maze_sel);
    sel_ok  = (sel_ext < NUM_MAZES);
  end

  // Next-state and next-output logic; outputs derive from the upcoming state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_d      = clr_q;
    sel_d      = sel_q;
    rom_addr_d = rom_addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          clr_d   = clear | ~sel_ok;
          sel_d   = maze_sel;
          idx_d   = '0;
          wdata_d = '0;
          state_d = clr_d ? WRITE : FETCH;
        end
      end
      FETCH: begin
        state_d = WAIT_ROM;
      end
      WAIT_ROM: begin
        wdata_d = rom_q;
        state_d = WRITE;
      end
      WRITE: begin
        if (!avm.AVM_WAITREQUEST) begin
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = clr_q ? WRITE : FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The ROM address is presented during FETCH so rom_q lands in WAIT_ROM.
    if (state_d == FETCH) begin
      rom_addr_d = ROM_AW'(32'(sel_d) * NUM_WORDS + 32'(idx_d));
    end

    write_d = (state_d == WRITE);
    busy_d  = (state_d inside {FETCH, WAIT_ROM, WRITE});
    done_d  = (state_d == DONE);
    be_d    = write_d ? 4'hF : 4'h0;
    addr_d  = ADDR_W'(idx_d);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      clr_q      <= 1'b0;
      sel_q      <= '0;
      rom_addr_q <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      write_q    <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_q      <= clr_d;
      sel_q      <= sel_d;
      rom_addr_q <= rom_addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      write_q    <= write_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign rom_addr          = rom_addr_q;
  assign avm.AVM_ADDR      = addr_q;
  assign avm.AVM_WRITE     = write_q;
  assign avm.AVM_CS        = write_q;
  assign avm.AVM_BYTE_EN   = be_q;
  assign avm.AVM_WRITEDATA = wdata_q;

endmodule

// File: tb/tb_maze_avl_writer.sv
// Directed bench for maze_avl_writer with a behavioural slave RAM and the maze ROM beside it.
module tb_maze_avl_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clear;
  logic [1:0]  maze_sel;
  logic        busy;
  logic        done;
  logic [11:0] rom_addr;
  logic [31:0] rom_q;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem    [0:1023];
  int          wcount [0:1023];

  int          r_done_cycle, r_done_cnt, r_first_wr, r_wr_cycles;
  logic [31:0] r_first_data;
  logic [9:0]  r_first_addr;
  logic [3:0]  r_first_be;
  logic [11:0] r_rom_addr_c1;
  int          r_rom_moved, r_cs_bad, r_be_bad;
  int          r_stall_seen, r_hold_bad;
  logic        r_busy_after, r_post_write, r_post_busy;

  maze_avl_writer_if #(.ADDR_W(10)) bus ();

  maze_avl_writer #(
    .NUM_WORDS(600),
    .NUM_MAZES(3),
    .ADDR_W   (10),
    .ROM_AW   (12)
  ) dut (
    .CLK     (clk),
    .RESET   (rst),
    .start   (start),
    .clear   (clear),
    .maze_sel(maze_sel),
    .busy    (busy),
    .done    (done),
    .rom_addr(rom_addr),
    .rom_q   (rom_q),
    .avm     (bus)
  );

  maze_rom #(.AW(12), .DEPTH(1800)) rom (
    .CLK (clk),
    .addr(rom_addr),
    .q   (rom_q)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] exp_rom(input int a);
    logic [11:0] t;
    t = 12'(a);
    return {4'hA, t, 4'h5, ~t};
  endfunction

  // Drives one transfer and records observations; comparisons live in the test tasks.
  task automatic run_xfer(input bit clr, input logic [1:0] sel, input int stall_word,
                          input int stall_len, input int restart_word,
                          input bit start_in_done, input int reset_word);
    int n, stalls, rst_cnt;
    bit restarted, did_rst, done_start;
    logic [31:0] hold_data;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hDEAD_BEEF;
      wcount[i] = 0;
    end
    r_done_cycle = -1; r_done_cnt = 0; r_first_wr = -1; r_wr_cycles = 0;
    r_first_data = '1; r_first_addr = '1; r_first_be = '0; r_rom_addr_c1 = '1;
    r_rom_moved = 0; r_cs_bad = 0; r_be_bad = 0; r_stall_seen = 0; r_hold_bad = 0;
    r_busy_after = 1'b1; r_post_write = 1'b1; r_post_busy = 1'b1;
    stalls = 0; rst_cnt = -1; restarted = 0; did_rst = 0; done_start = 0; hold_data = '0;
    @(negedge clk);
    clear = clr; maze_sel = sel; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 6000) begin
      start = 1'b0;
      if (rst_cnt == 0) begin
        r_post_write = bus.AVM_WRITE;
        r_post_busy  = busy;
        rst = 1'b0;
      end
      if (n == 1) r_rom_addr_c1 = rom_addr;
      if (rom_addr != 12'd0) r_rom_moved++;
      if (bus.AVM_CS !== bus.AVM_WRITE) r_cs_bad++;
      if (bus.AVM_BYTE_EN !== (bus.AVM_WRITE ? 4'hF : 4'h0)) r_be_bad++;
      if (done) begin
        r_done_cnt++;
        if (r_done_cycle < 0) r_done_cycle = n;
        if (start_in_done && !done_start) begin
          start = 1'b1;
          done_start = 1;
        end
      end
      if (r_done_cycle > 0 && n == r_done_cycle + 3) begin
        r_busy_after = busy;
        break;
      end
      bus.AVM_WAITREQUEST = 1'b0;
      if (bus.AVM_WRITE) begin
        r_wr_cycles++;
        if (r_first_wr < 0) begin
          r_first_wr   = n;
          r_first_data = bus.AVM_WRITEDATA;
          r_first_addr = bus.AVM_ADDR;
          r_first_be   = bus.AVM_BYTE_EN;
        end
        if (int'(bus.AVM_ADDR) == stall_word) begin
          if (r_stall_seen == 0) hold_data = bus.AVM_WRITEDATA;
          else if (bus.AVM_WRITEDATA !== hold_data) r_hold_bad++;
          r_stall_seen++;
          if (stalls < stall_len) begin
            bus.AVM_WAITREQUEST = 1'b1;
            stalls++;
          end
        end
        if (int'(bus.AVM_ADDR) == restart_word && !restarted) begin
          start = 1'b1; clear = ~clr; maze_sel = ~sel; restarted = 1;
        end
        if (int'(bus.AVM_ADDR) == reset_word && !did_rst) begin
          rst = 1'b1; did_rst = 1; rst_cnt = 1;
        end
        if (!bus.AVM_WAITREQUEST) begin
          mem[bus.AVM_ADDR] = bus.AVM_WRITEDATA;
          wcount[bus.AVM_ADDR]++;
        end
      end
      if (rst_cnt >= 0) begin
        if (rst_cnt == -20) break;
        rst_cnt--;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    bus.AVM_WAITREQUEST = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear = 1'b0; maze_sel = 2'd0; bus.AVM_WAITREQUEST = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (bus.AVM_WRITE !== 1'b0) begin bad++; $display("FAIL reset_write got=%b want=0", bus.AVM_WRITE); end
    total++; if (bus.AVM_CS !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b want=0", bus.AVM_CS); end
    total++; if (bus.AVM_BYTE_EN !== 4'h0) begin bad++; $display("FAIL reset_be got=%h want=0", bus.AVM_BYTE_EN); end
    total++; if (bus.AVM_ADDR !== 10'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", bus.AVM_ADDR); end
    total++; if (bus.AVM_WRITEDATA !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", bus.AVM_WRITEDATA); end
    total++; if (rom_addr !== 12'd0) begin bad++; $display("FAIL reset_rom_addr got=%0d want=0", rom_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bad_sel();
    int bw = 0;
    run_xfer(1'b0, 2'd3, -1, 0, -1, 1'b0, -1);
    for (int i = 0; i < 600; i++) if (mem[i] !== 32'h0 || wcount[i] != 1) bw++;
    total++; if (r_done_cycle != 601) begin bad++; $display("FAIL badsel_done_cycle got=%0d want=601", r_done_cycle); end
    total++; if (r_first_wr != 1) begin bad++; $display("FAIL badsel_first_write got=%0d want=1", r_first_wr); end
    total++; if (r_rom_moved != 0) begin bad++; $display("FAIL badsel_rom_addr_moved got=%0d want=0", r_rom_moved); end
    total++; if (bw != 0) begin bad++; $display("FAIL badsel_ram_words got=%0d bad want=0", bw); end
  endtask

  task automatic test_copy();
    int bw = 0;
    run_xfer(1'b0, 2'd1, -1, 0, -1, 1'b0, -1);
    for (int i = 0; i < 600; i++) if (mem[i] !== exp_rom(600 + i) || wcount[i] != 1) bw++;
    total++; if (r_rom_addr_c1 !== 12'd600) begin bad++; $display("FAIL copy_rom_addr got=%0d want=600", r_rom_addr_c1); end
    total++; if (r_first_wr != 3) begin bad++; $display("FAIL copy_first_write got=%0d want=3", r_first_wr); end
    total++; if (r_first_addr !== 10'd0) begin bad++; $display("FAIL copy_first_addr got=%0d want=0", r_first_addr); end
    total++; if (r_first_data !== exp_rom(600)) begin bad++; $display("FAIL copy_first_data got=%h want=%h", r_first_data, exp_rom(600)); end
    total++; if (r_first_be !== 4'hF) begin bad++; $display("FAIL copy_first_be got=%h want=f", r_first_be); end
    total++; if (r_done_cycle != 1801) begin bad++; $display("FAIL copy_done_cycle got=%0d want=1801", r_done_cycle); end
    total++; if (r_done_cnt != 1) begin bad++; $display("FAIL copy_done_pulses got=%0d want=1", r_done_cnt); end
    total++; if (r_wr_cycles != 600) begin bad++; $display("FAIL copy_write_cycles got=%0d want=600", r_wr_cycles); end
    total++; if (r_cs_bad + r_be_bad != 0) begin bad++; $display("FAIL copy_cs_be got=%0d want=0", r_cs_bad + r_be_bad); end
    total++; if (bw != 0) begin bad++; $display("FAIL copy_ram_words got=%0d bad want=0", bw); end
  endtask

  task automatic test_clear();
    int bw = 0;
    run_xfer(1'b1, 2'd2, -1, 0, -1, 1'b0, -1);
    for (int i = 0; i < 600; i++) if (mem[i] !== 32'h0 || wcount[i] != 1) bw++;
    total++; if (r_first_wr != 1) begin bad++; $display("FAIL clear_first_write got=%0d want=1", r_first_wr); end
    total++; if (r_done_cycle != 601) begin bad++; $display("FAIL clear_done_cycle got=%0d want=601", r_done_cycle); end
    total++; if (r_wr_cycles != 600) begin bad++; $display("FAIL clear_write_cycles got=%0d want=600", r_wr_cycles); end
    total++; if (bw != 0) begin bad++; $display("FAIL clear_ram_words got=%0d bad want=0", bw); end
  endtask

  task automatic test_stall();
    int bw = 0;
    run_xfer(1'b0, 2'd1, 10, 5, -1, 1'b0, -1);
    for (int i = 0; i < 600; i++) if (mem[i] !== exp_rom(600 + i) || wcount[i] != 1) bw++;
    total++; if (r_stall_seen != 6) begin bad++; $display("FAIL stall_addr_hold got=%0d want=6", r_stall_seen); end
    total++; if (r_hold_bad != 0) begin bad++; $display("FAIL stall_data_hold got=%0d want=0", r_hold_bad); end
    total++; if (r_done_cycle != 1806) begin bad++; $display("FAIL stall_done_cycle got=%0d want=1806", r_done_cycle); end
    total++; if (bw != 0) begin bad++; $display("FAIL stall_ram_words got=%0d bad want=0", bw); end
  endtask

  task automatic test_back_to_back();
    int bw = 0;
    run_xfer(1'b0, 2'd1, -1, 0, 300, 1'b1, -1);
    for (int i = 0; i < 600; i++) if (mem[i] !== exp_rom(600 + i) || wcount[i] != 1) bw++;
    total++; if (r_done_cycle != 1801) begin bad++; $display("FAIL restart_done_cycle got=%0d want=1801", r_done_cycle); end
    total++; if (r_done_cnt != 1) begin bad++; $display("FAIL restart_done_pulses got=%0d want=1", r_done_cnt); end
    total++; if (r_busy_after !== 1'b0) begin bad++; $display("FAIL restart_busy_after got=%b want=0", r_busy_after); end
    total++; if (bw != 0) begin bad++; $display("FAIL restart_ram_words got=%0d bad want=0", bw); end
  endtask

  task automatic test_reset_mid();
    int bw = 0;
    run_xfer(1'b0, 2'd2, -1, 0, -1, 1'b0, 42);
    total++; if (r_post_write !== 1'b0) begin bad++; $display("FAIL midrst_write got=%b want=0", r_post_write); end
    total++; if (r_post_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", r_post_busy); end
    total++; if (r_done_cnt != 0) begin bad++; $display("FAIL midrst_done_pulses got=%0d want=0", r_done_cnt); end
    total++; if (mem[41] !== exp_rom(1241) || wcount[100] != 0) begin bad++; $display("FAIL midrst_partial got=%h/%0d want=%h/0", mem[41], wcount[100], exp_rom(1241)); end
    run_xfer(1'b0, 2'd0, -1, 0, -1, 1'b0, -1);
    for (int i = 0; i < 600; i++) if (mem[i] !== exp_rom(i) || wcount[i] != 1) bw++;
    total++; if (r_first_addr !== 10'd0) begin bad++; $display("FAIL midrst_restart_addr got=%0d want=0", r_first_addr); end
    total++; if (r_done_cycle != 1801) begin bad++; $display("FAIL midrst_restart_done got=%0d want=1801", r_done_cycle); end
    total++; if (bw != 0) begin bad++; $display("FAIL midrst_ram_words got=%0d bad want=0", bw); end
  endtask

  initial begin
    test_reset();
    test_bad_sel();
    test_copy();
    test_clear();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
